// File: rtl/intra_pred_weighted_sum.sv
// Two-stage weighted-sum stage of intra prediction: per-pixel products in stage 1,
// rounding/shift/saturation plus block tile tracking in stage 2, valid/ready on both sides.
`timescale 1ns/1ps
module intra_pred_weighted_sum #(
  parameter int PIX_W = 8,
  parameter int ACC_W = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 angle_or_planar,
  input  logic [2:0]           log2_size,
  input  logic [16*PIX_W-1:0]  weight1,
  input  logic [16*PIX_W-1:0]  weight2,
  input  logic [16*PIX_W-1:0]  ref_a,
  input  logic [16*PIX_W-1:0]  ref_b,
  input  logic [PIX_W-1:0]     top_right,
  input  logic [PIX_W-1:0]     bottom_left,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*PIX_W-1:0]  pred,
  output logic                 out_last
);
  localparam int NPIX = 16;

  logic             en1, en2;
  logic             s1_valid_reg, s1_angular_reg;
  logic [2:0]       s1_lg_reg;
  logic             out_valid_reg, out_last_reg;
  logic [5:0]       tcnt_reg;
  logic [2:0]       last_lg_reg;
  logic [2:0]       lg_in;
  logic [ACC_W-1:0] nt_in, tr_w, bl_w, rnd_s2;
  logic [2:0]       shamt_s2;
  logic [5:0]       tile_idx, tile_max;
  logic             tile_last;

  assign en2       = !out_valid_reg || out_ready;
  assign en1       = !s1_valid_reg || en2;
  assign in_ready  = en1;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;

  always_comb begin
    lg_in = log2_size;
    if (log2_size < 3'd2)
      lg_in = 3'd2;
    else if (log2_size > 3'd5)
      lg_in = 3'd5;
  end

  assign nt_in = ACC_W'(1) << lg_in;
  assign tr_w  = ACC_W'(top_right);
  assign bl_w  = ACC_W'(bottom_left);

  // Angular and planar share one adder tree: only rounding term and shift differ.
  assign rnd_s2   = s1_angular_reg ? ACC_W'(16) : (ACC_W'(1) << s1_lg_reg);
  assign shamt_s2 = s1_angular_reg ? 3'd5 : (s1_lg_reg + 3'd1);

  // Tile position within its block is fixed when the tile enters stage 2; tiles
  // leave in the same order, so this matches counting at the output transfer.
  assign tile_idx = (s1_lg_reg == last_lg_reg) ? tcnt_reg : 6'd0;

  always_comb begin
    case (s1_lg_reg)
      3'd2:    tile_max = 6'd0;
      3'd3:    tile_max = 6'd3;
      3'd4:    tile_max = 6'd15;
      default: tile_max = 6'd63;
    endcase
  end

  assign tile_last = (tile_idx == tile_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s1_angular_reg <= 1'b0;
      s1_lg_reg      <= 3'd0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      tcnt_reg       <= 6'd0;
      last_lg_reg    <= 3'd0;
    end else begin
      if (en1) begin
        s1_valid_reg   <= in_valid;
        s1_angular_reg <= angle_or_planar;
        s1_lg_reg      <= lg_in;
      end
      if (en2) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_last_reg <= tile_last;
          tcnt_reg     <= tile_last ? 6'd0 : (tile_idx + 6'd1);
          last_lg_reg  <= s1_lg_reg;
        end else begin
          out_last_reg <= 1'b0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NPIX; gi++) begin : g_pix
    logic [ACC_W-1:0] w1, w2, ra, rb;
    logic [ACC_W-1:0] pa_next, pb_next, pc_next, pd_next;
    logic [ACC_W-1:0] pa_reg, pb_reg, pc_reg, pd_reg;
    logic [ACC_W-1:0] sum, shifted;
    logic [PIX_W-1:0] pred_reg;

    assign w1 = ACC_W'(weight1[gi*PIX_W +: PIX_W]);
    assign w2 = ACC_W'(weight2[gi*PIX_W +: PIX_W]);
    assign ra = ACC_W'(ref_a[gi*PIX_W +: PIX_W]);
    assign rb = ACC_W'(ref_b[gi*PIX_W +: PIX_W]);

    assign pa_next = angle_or_planar ? (w2 * ra) : ((nt_in - w2) * ra);
    assign pb_next = angle_or_planar ? (w1 * rb) : ((nt_in - w1) * rb);
    assign pc_next = angle_or_planar ? '0 : (w1 * tr_w);
    assign pd_next = angle_or_planar ? '0 : (w2 * bl_w);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pa_reg <= '0;
        pb_reg <= '0;
        pc_reg <= '0;
        pd_reg <= '0;
      end else if (en1) begin
        pa_reg <= pa_next;
        pb_reg <= pb_next;
        pc_reg <= pc_next;
        pd_reg <= pd_next;
      end
    end

    assign sum     = pa_reg + pb_reg + pc_reg + pd_reg + rnd_s2;
    assign shifted = sum >> shamt_s2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        pred_reg <= '0;
      else if (en2)
        pred_reg <= (|shifted[ACC_W-1:PIX_W]) ? '1 : shifted[PIX_W-1:0];
    end

    assign pred[gi*PIX_W +: PIX_W] = pred_reg;
  end

endmodule

// File: tb/tb_intra_pred_weighted_sum.sv
// Bench for intra_pred_weighted_sum: directed vector table, stall/reset sequences and
// random traffic scored against a plain-arithmetic model of the prediction formulas.
`timescale 1ns/1ps
module tb_intra_pred_weighted_sum;
  typedef struct packed {
    logic         angular;
    logic [2:0]   log2;
    logic [127:0] w1, w2, ra, rb;
    logic [7:0]   tr, bl;
  } tile_t;

  typedef struct {
    tile_t      t;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [127:0] pred;
    bit           last;
    int           cyc;
  } exp_t;

  logic         clk = 0, rst = 0;
  logic         in_valid = 0, in_ready, angle_or_planar = 0;
  logic [2:0]   log2_size = 0;
  logic [127:0] weight1 = 0, weight2 = 0, ref_a = 0, ref_b = 0;
  logic [7:0]   top_right = 0, bottom_left = 0;
  logic         out_valid, out_ready = 0, out_last;
  logic [127:0] pred;

  int   n_checks = 0, n_fail = 0, cyc = 0;
  int   m_idx = 0, m_lg = -1;
  bit   chk_lat = 0;
  exp_t expq[$];
  int   last_pos[$];

  always #5 clk = ~clk;

  intra_pred_weighted_sum #(.PIX_W(8), .ACC_W(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .angle_or_planar(angle_or_planar), .log2_size(log2_size),
    .weight1(weight1), .weight2(weight2), .ref_a(ref_a), .ref_b(ref_b),
    .top_right(top_right), .bottom_left(bottom_left),
    .out_valid(out_valid), .out_ready(out_ready), .pred(pred), .out_last(out_last)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic int clamp_lg(input logic [2:0] l);
    return (l < 2) ? 2 : ((l > 5) ? 5 : int'(l));
  endfunction

  function automatic logic [127:0] rep(input logic [7:0] v);
    return {16{v}};
  endfunction

  function automatic logic [127:0] model_pred(input tile_t t);
    logic [127:0] r;
    int lg, nt, w1, w2, ra, rb, tr, bl, v;
    lg = clamp_lg(t.log2);
    nt = 1 << lg;
    tr = int'(t.tr);
    bl = int'(t.bl);
    r  = '0;
    for (int k = 0; k < 16; k++) begin
      w1 = int'(t.w1[k*8 +: 8]);
      w2 = int'(t.w2[k*8 +: 8]);
      ra = int'(t.ra[k*8 +: 8]);
      rb = int'(t.rb[k*8 +: 8]);
      if (t.angular)
        v = (w2 * ra + w1 * rb + 16) / 32;
      else
        v = ((nt - w2) * ra + (nt - w1) * rb + w1 * tr + w2 * bl + nt) / (2 * nt);
      r[k*8 +: 8] = (v > 255) ? 8'd255 : 8'(v);
    end
    return r;
  endfunction

  function automatic tile_t rand_tile(input logic [2:0] l);
    tile_t t;
    int nt, f;
    t = '0;
    t.angular = 1'($urandom_range(0, 1));
    t.log2 = l;
    nt = 1 << clamp_lg(l);
    for (int k = 0; k < 16; k++) begin
      if (t.angular) begin
        f = $urandom_range(0, 32);
        t.w1[k*8 +: 8] = 8'(f);
        t.w2[k*8 +: 8] = 8'(32 - f);
      end else begin
        t.w1[k*8 +: 8] = 8'($urandom_range(1, nt));
        t.w2[k*8 +: 8] = 8'($urandom_range(1, nt));
      end
      t.ra[k*8 +: 8] = 8'($urandom_range(0, 255));
      t.rb[k*8 +: 8] = 8'($urandom_range(0, 255));
    end
    t.tr = 8'($urandom_range(0, 255));
    t.bl = 8'($urandom_range(0, 255));
    return t;
  endfunction

  // Block bookkeeping: a tile whose size differs from the previous one starts a new block.
  function automatic bit model_last(input logic [2:0] l);
    int lg;
    bit last;
    lg = clamp_lg(l);
    if (lg != m_lg) m_idx = 0;
    last  = (m_idx == (1 << (2 * (lg - 2))) - 1);
    m_idx = last ? 0 : m_idx + 1;
    m_lg  = lg;
    return last;
  endfunction

  // One clock: drive, settle, score any transfers, advance past the edge.
  task automatic step(input bit iv, input tile_t t, input logic [127:0] exp_pred, input bit ordy,
                      output bit acc, output bit ov, output bit oxf, output bit olast,
                      output logic [127:0] opred);
    exp_t e;
    in_valid = iv; angle_or_planar = t.angular; log2_size = t.log2;
    weight1 = t.w1; weight2 = t.w2; ref_a = t.ra; ref_b = t.rb;
    top_right = t.tr; bottom_left = t.bl; out_ready = ordy;
    #1;
    acc = iv && in_ready;
    ov = out_valid;
    oxf = out_valid && out_ready;
    olast = out_last;
    opred = pred;
    if (oxf) begin
      if (expq.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("pred", pred, e.pred);
        chk("out_last", out_last, e.last);
        if (chk_lat) chk("latency", cyc - e.cyc, 2);
      end
    end
    if (acc) begin
      e.pred = exp_pred;
      e.last = model_last(t.log2);
      e.cyc  = cyc;
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    bit a, v, x, l;
    logic [127:0] p;
    for (int i = 0; i < 40 && expq.size() > 0; i++) step(0, '0, '0, 1, a, v, x, l, p);
    chk("drain_empty", expq.size(), 0);
  endtask

  task automatic run_stream(input logic [2:0] l, input int n);
    bit a, v, x, ol;
    logic [127:0] p;
    tile_t t;
    int sent, outs;
    sent = 0; outs = 0;
    last_pos.delete();
    for (int s = 0; s < n + 40 && (sent < n || expq.size() > 0); s++) begin
      t = rand_tile(l);
      step(sent < n, t, model_pred(t), 1, a, v, x, ol, p);
      if (a) sent++;
      if (x) begin
        outs++;
        if (ol) last_pos.push_back(outs);
      end
    end
    chk("stream_outputs", outs, n);
  endtask

  vec_t vecs[8];

  initial begin
    bit a, v, x, ol;
    logic [127:0] p, e1;
    tile_t t, t1, t2, t3;
    int out_steps[$];
    logic [2:0] cur_lg;

    #1 rst = 1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pred", pred, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // {mode, log2, w1, w2, ref_a, ref_b, top_right, bottom_left} -> uniform pred
    vecs[0] = '{'{1'b1, 3'd2, rep(0),  rep(32), rep(100), rep(200), 8'd0,   8'd0},   8'd100};
    vecs[1] = '{'{1'b1, 3'd2, rep(16), rep(16), rep(10),  rep(21),  8'd0,   8'd0},   8'd16};
    vecs[2] = '{'{1'b0, 3'd5, rep(32), rep(32), rep(0),   rep(0),   8'd255, 8'd255}, 8'd255};
    vecs[3] = '{'{1'b0, 3'd3, rep(8),  rep(8),  rep(0),   rep(0),   8'd40,  8'd40},  8'd40};
    vecs[4] = '{'{1'b0, 3'd2, rep(1),  rep(1),  rep(100), rep(100), 8'd100, 8'd100}, 8'd100};
    vecs[5] = '{'{1'b0, 3'd2, rep(4),  rep(1),  rep(0),   rep(0),   8'd200, 8'd0},   8'd100};
    vecs[6] = '{'{1'b1, 3'd2, rep(32), rep(0),  rep(5),   rep(250), 8'd0,   8'd0},   8'd250};
    vecs[7] = '{'{1'b0, 3'd0, rep(4),  rep(4),  rep(0),   rep(0),   8'd80,  8'd80},  8'd80};

    chk_lat = 1;
    for (int i = 0; i < 8; i++) begin
      step(1, vecs[i].t, rep(vecs[i].exp), 1, a, v, x, ol, p);
      chk("vec_accept", a, 1);
      drain();
    end

    run_stream(3'd3, 8);
    chk("lg3_last_count", last_pos.size(), 2);
    if (last_pos.size() == 2) begin
      chk("lg3_last_pos0", last_pos[0], 4);
      chk("lg3_last_pos1", last_pos[1], 8);
    end
    run_stream(3'd7, 64);
    chk("lg7_last_count", last_pos.size(), 1);
    if (last_pos.size() == 1) chk("lg7_last_pos", last_pos[0], 64);
    chk_lat = 0;

    // Three tiles against a sink that stays stalled for four cycles.
    t1 = rand_tile(3'd2); t2 = rand_tile(3'd2); t3 = rand_tile(3'd2);
    e1 = model_pred(t1);
    begin
      int sent;
      sent = 0;
      for (int s = 0; s < 20 && (sent < 3 || expq.size() > 0); s++) begin
        t = (sent == 0) ? t1 : ((sent == 1) ? t2 : t3);
        step(sent < 3, t, model_pred(t), s >= 4, a, v, x, ol, p);
        if (s == 2) begin
          chk("stall_in_ready", a, 0);
          chk("stall_valid", v, 1);
          chk("stall_hold_a", p, e1);
        end
        if (s == 3) chk("stall_hold_b", p, e1);
        if (a) sent++;
        if (x) out_steps.push_back(s);
      end
    end
    chk("stall_out_count", out_steps.size(), 3);
    if (out_steps.size() == 3) begin
      chk("stall_first_out", out_steps[0], 4);
      chk("stall_no_gap", out_steps[2] - out_steps[0], 2);
    end

    cur_lg = 3'($urandom_range(0, 7));
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 7) == 0) cur_lg = 3'($urandom_range(0, 7));
      t = rand_tile(cur_lg);
      step($urandom_range(0, 3) != 0, t, model_pred(t), $urandom_range(0, 3) != 0,
           a, v, x, ol, p);
    end
    drain();

    // Reset with two tiles in flight, then a fresh 8x8 block.
    step(1, vecs[0].t, rep(vecs[0].exp), 0, a, v, x, ol, p);
    step(1, vecs[1].t, rep(vecs[1].exp), 0, a, v, x, ol, p);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_pred", pred, 0);
    chk("mid_rst_last", out_last, 0);
    expq.delete();
    m_idx = 0;
    m_lg  = -1;
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    run_stream(3'd3, 4);
    chk("post_rst_last_count", last_pos.size(), 1);
    if (last_pos.size() == 1) chk("post_rst_last_pos", last_pos[0], 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule
